// File: rtl/snake_scoreboard_mux.sv
// ---------------------------------------------------------------------------
// snake_scoreboard_mux
//
// Purpose:
//   Score display driver for the snake game. A binary score is converted to
//   BCD by a sequential shift-add-3 (double-dabble) engine. The converted
//   value is then scanned one digit at a time onto a shared seven-segment
//   bus, with one enable line per digit.
//
// Parameters:
//   SCORE_WIDTH  width of the binary score input
//   NUM_DIGITS   number of displayed decimal digits (1-8)
//   REFRESH_DIV  clock cycles each digit stays enabled (>=1)
//   ACTIVE_LOW   1 = segments/enables asserted low, 0 = asserted high
//
// Ports:
//   i_Clk          system clock (single domain)
//   i_Reset        asynchronous, active-high reset
//   i_Score        binary score, sampled together with i_ScoreValid
//   i_ScoreValid   one-cycle load strobe
//   o_Busy         a conversion is in progress
//   o_Overflow     displayed value is saturated to all nines
//   o_Segments     segment bus {g,f,e,d,c,b,a}
//   o_DigitEnable  one-hot digit enable, bit 0 = least-significant digit
//
// Optional feature macro:
//   SNAKE_SCOREBOARD_LZ_BLANK_EN - leading-zero blanking. Digits above the
//   most significant nonzero digit are driven dark. Digit 0 is never
//   blanked, and an overflowed (all nines) value is never blanked.
// ---------------------------------------------------------------------------
module snake_scoreboard_mux #(
  parameter int SCORE_WIDTH = 14,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic [SCORE_WIDTH-1:0] i_Score,
  input  logic                   i_ScoreValid,
  output logic                   o_Busy,
  output logic                   o_Overflow,
  output logic [6:0]             o_Segments,
  output logic [NUM_DIGITS-1:0]  o_DigitEnable
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(SCORE_WIDTH + 1);
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0] SEG_ZERO = 7'b0111111;

  // Largest score that fits in NUM_DIGITS decimal digits (10^N - 1).
  function automatic longint unsigned max_display(input int digits);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

  localparam longint unsigned MAX_SCORE = max_display(NUM_DIGITS);

  // Standard seven-segment patterns; anything that is not 0-9 goes dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] s;
    case (nibble)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] seg_pol(input logic [6:0] s);
    return (ACTIVE_LOW != 0) ? ~s : s;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] en_pol(input logic [NUM_DIGITS-1:0] e);
    return (ACTIVE_LOW != 0) ? ~e : e;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  state_t state, state_next;

  logic [SCORE_WIDTH-1:0] score_q;
  logic                   valid_q;

  logic [SCORE_WIDTH-1:0] pending_score;
  logic                   pending_valid;

  logic [SCORE_WIDTH-1:0] bin_reg;
  logic [BCD_W-1:0]       bcd_reg;
  logic [BCD_W-1:0]       bcd_adj;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   conv_ovf;

  logic [BCD_W-1:0]       disp_reg;
  logic [NUM_DIGITS-1:0]  blank_reg;

  logic [PRE_W-1:0]       prescaler;
  logic [IDX_W-1:0]       digit_idx;

  logic                   load_en;
  logic                   shift_en;
  logic                   commit_en;
  logic                   pend_wr;
  logic [SCORE_WIDTH-1:0] load_value;
  logic                   last_bit;

  // The strobe and score are registered once before the converter looks at
  // them, so the FSM only ever sees a clean, registered request.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      score_q <= '0;
      valid_q <= 1'b0;
    end else begin
      score_q <= i_Score;
      valid_q <= i_ScoreValid;
    end
  end

  // Converter state register.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign last_bit = (bit_cnt == CNT_W'(SCORE_WIDTH - 1));

  // Next-state logic. A strobe arriving during COMMIT is treated like a
  // pending load, so back-to-back conversions never pass through IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (valid_q) state_next = ST_SHIFT;
      ST_SHIFT:  if (last_bit) state_next = ST_COMMIT;
      ST_COMMIT: state_next = (pending_valid || valid_q) ? ST_SHIFT : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Converter control outputs. In COMMIT the freshest strobe wins over the
  // pending slot, which matches "last value wins".
  always_comb begin
    o_Busy     = (state != ST_IDLE);
    shift_en   = (state == ST_SHIFT);
    commit_en  = (state == ST_COMMIT);
    load_en    = ((state == ST_IDLE) && valid_q) ||
                 ((state == ST_COMMIT) && (pending_valid || valid_q));
    pend_wr    = valid_q && (state == ST_SHIFT);
    load_value = ((state == ST_COMMIT) && !valid_q) ? pending_score : score_q;
  end

  // Single-entry pending slot; a newer request simply overwrites it.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      pending_valid <= 1'b0;
      pending_score <= '0;
    end else if (commit_en) begin
      pending_valid <= 1'b0;
    end else if (pend_wr) begin
      pending_valid <= 1'b1;
      pending_score <= score_q;
    end
  end

  // Add-3 correction applied to every BCD nibble before each shift.
  always_comb begin
    bcd_adj = bcd_reg;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_reg[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_reg[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Double-dabble datapath. The overflow flag is decided at capture time so
  // that COMMIT can substitute all nines without looking at the BCD result.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      bin_reg  <= '0;
      bcd_reg  <= '0;
      bit_cnt  <= '0;
      conv_ovf <= 1'b0;
    end else if (load_en) begin
      bin_reg  <= load_value;
      bcd_reg  <= '0;
      bit_cnt  <= '0;
      conv_ovf <= (64'(load_value) > MAX_SCORE);
    end else if (shift_en) begin
      {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
      bit_cnt            <= bit_cnt + CNT_W'(1);
    end
  end

  // Display register only moves in COMMIT, so the scan never catches a
  // half-converted value.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      disp_reg   <= '0;
      o_Overflow <= 1'b0;
    end else if (commit_en) begin
      o_Overflow <= conv_ovf;
      if (conv_ovf) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          disp_reg[i*4 +: 4] <= 4'd9;
        end
      end else begin
        disp_reg <= bcd_reg;
      end
    end
  end

`ifdef SNAKE_SCOREBOARD_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_next;

  // A digit is blank when it and every digit above it are zero. Walking
  // from the top down, "seen" marks the first nonzero digit.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    blank_next = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen          = seen | (bcd_reg[i*4 +: 4] != 4'd0);
      blank_next[i] = !seen && !conv_ovf;
    end
  end

  // Blank mask travels with the display register.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      blank_reg <= '0;
    end else if (commit_en) begin
      blank_reg <= blank_next;
    end
  end
`else
  assign blank_reg = '0;
`endif

  // Refresh prescaler and digit index scan.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      prescaler <= '0;
      digit_idx <= '0;
    end else if (prescaler == PRE_W'(REFRESH_DIV - 1)) begin
      prescaler <= '0;
      if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
        digit_idx <= '0;
      end else begin
        digit_idx <= digit_idx + IDX_W'(1);
      end
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  logic [3:0]            sel_nibble;
  logic                  sel_blank;
  logic [NUM_DIGITS-1:0] en_onehot;
  logic [6:0]            seg_raw;

  // Select the scanned digit and build the raw (active-high) output values.
  always_comb begin
    sel_nibble = 4'd0;
    sel_blank  = 1'b0;
    en_onehot  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        sel_nibble   = disp_reg[i*4 +: 4];
        sel_blank    = blank_reg[i];
        en_onehot[i] = 1'b1;
      end
    end
    seg_raw = sel_blank ? 7'b0000000 : seg_decode(sel_nibble);
  end

  // Output register; polarity is applied here so the pins never glitch.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Segments    <= seg_pol(SEG_ZERO);
      o_DigitEnable <= en_pol(NUM_DIGITS'(1));
    end else begin
      o_Segments    <= seg_pol(seg_raw);
      o_DigitEnable <= en_pol(en_onehot);
    end
  end

endmodule

// File: tb/tb_snake_scoreboard_mux.sv
// ---------------------------------------------------------------------------
// tb_snake_scoreboard_mux
//
// Self-checking bench for snake_scoreboard_mux. A transaction-level model
// tracks when each conversion completes and what decimal value is shown,
// and expected segment patterns are derived with plain decimal arithmetic.
// ---------------------------------------------------------------------------
module tb_snake_scoreboard_mux;

  localparam int SW  = 14;
  localparam int ND  = 4;
  localparam int DIV = 4;
  localparam int AL  = 1;

  logic          clk;
  logic          i_Reset;
  logic [SW-1:0] i_Score;
  logic          i_ScoreValid;
  logic          o_Busy;
  logic          o_Overflow;
  logic [6:0]    o_Segments;
  logic [ND-1:0] o_DigitEnable;

  snake_scoreboard_mux #(
    .SCORE_WIDTH (SW),
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (DIV),
    .ACTIVE_LOW  (AL)
  ) dut (
    .i_Clk         (clk),
    .i_Reset       (i_Reset),
    .i_Score       (i_Score),
    .i_ScoreValid  (i_ScoreValid),
    .o_Busy        (o_Busy),
    .o_Overflow    (o_Overflow),
    .o_Segments    (o_Segments),
    .o_DigitEnable (o_DigitEnable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Seven-segment reference patterns {g,f,e,d,c,b,a} for digits 0-9.
  logic [6:0] seg_table [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  // Model state: edges since reset release, shown value, conversion schedule.
  int n;
  int disp_val;
  bit disp_ovf;
  bit active;
  int cur_val;
  int done_edge;
  int busy_from;
  bit pend_valid;
  int pend_val;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t",
               tag, actual, expected, $time);
    end
  endtask

  function automatic int pow10(input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  // Pattern expected on the bus for digit d of the shown value.
  function automatic logic [6:0] expSeg(input int val, input bit ovf, input int d);
    int v;
    int dig;
    logic [6:0] s;
    v   = ovf ? pow10(ND) - 1 : val;
    dig = (v / pow10(d)) % 10;
    s   = seg_table[dig];
`ifdef SNAKE_SCOREBOARD_LZ_BLANK_EN
    if (d > 0 && v < pow10(d)) s = 7'b0000000;
`endif
    return (AL != 0) ? ~s : s;
  endfunction

  function automatic logic [ND-1:0] expEn(input int d);
    logic [ND-1:0] e;
    e    = '0;
    e[d] = 1'b1;
    return (AL != 0) ? ~e : e;
  endfunction

  task automatic modelReset();
    n          = 0;
    disp_val   = 0;
    disp_ovf   = 1'b0;
    active     = 1'b0;
    cur_val    = 0;
    done_edge  = 0;
    busy_from  = 0;
    pend_valid = 1'b0;
    pend_val   = 0;
  endtask

  // Advance the model by one clock edge with the inputs sampled at it.
  task automatic modelEdge(input bit v, input int s,
                           output logic [6:0] exp_seg, output logic [ND-1:0] exp_en,
                           output bit exp_busy, output bit exp_ovf);
    int idx;
    int src_val;
    bit src_ovf;
    n++;
    idx     = ((n - 1) / DIV) % ND;
    src_val = disp_val;
    src_ovf = disp_ovf;
    if (active && n == done_edge) begin
      disp_ovf = (cur_val > pow10(ND) - 1);
      disp_val = disp_ovf ? pow10(ND) - 1 : cur_val;
      if (pend_valid) begin
        cur_val    = pend_val;
        done_edge  = n + SW + 1;
        pend_valid = 1'b0;
      end else begin
        active = 1'b0;
      end
    end
    if (v) begin
      if (active) begin
        pend_valid = 1'b1;
        pend_val   = s;
      end else begin
        active    = 1'b1;
        cur_val   = s;
        done_edge = n + SW + 2;
        busy_from = n + 1;
      end
    end
    exp_busy = active && (n >= busy_from);
    exp_ovf  = disp_ovf;
    exp_seg  = expSeg(src_val, src_ovf, idx);
    exp_en   = expEn(idx);
  endtask

  task automatic applyStimulus(input bit v, input int s);
    logic [6:0]    es;
    logic [ND-1:0] ee;
    bit            eb;
    bit            eo;
    @(negedge clk);
    i_ScoreValid = v;
    i_Score      = SW'(s);
    @(posedge clk);
    modelEdge(v, s, es, ee, eb, eo);
    #1;
    checkOutput("busy",     32'(o_Busy),        32'(eb));
    checkOutput("overflow", 32'(o_Overflow),    32'(eo));
    checkOutput("enable",   32'(o_DigitEnable), 32'(ee));
    checkOutput("segments", 32'(o_Segments),    32'(es));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 0);
  endtask

  // Assert reset mid-cycle, check the outputs fall back at once, then
  // release it shortly after a rising edge.
  task automatic applyReset();
    @(negedge clk);
    i_Reset      = 1'b1;
    i_ScoreValid = 1'b0;
    #1;
    checkOutput("rst_busy",     32'(o_Busy),        32'(0));
    checkOutput("rst_overflow", 32'(o_Overflow),    32'(0));
    checkOutput("rst_enable",   32'(o_DigitEnable), 32'(expEn(0)));
    checkOutput("rst_segments", 32'(o_Segments),    32'(expSeg(0, 1'b0, 0)));
    repeat (2) @(posedge clk);
    #2;
    i_Reset = 1'b0;
    modelReset();
  endtask

  initial begin
    int busy_cycles;
    int r;
    i_Reset      = 1'b1;
    i_ScoreValid = 1'b0;
    i_Score      = '0;
    modelReset();

    // Idle scan after reset: every digit shows "0".
    applyReset();
    idle(20);

    // Single conversion of 1234, with busy length measured.
    busy_cycles = 0;
    applyStimulus(1'b1, 1234);
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b0, 0);
      if (o_Busy) busy_cycles++;
    end
    checkOutput("busy_len", 32'(busy_cycles), 32'(SW + 1));
    idle(16);

    // Overflow saturates to all nines.
    applyStimulus(1'b1, 12000);
    idle(40);

    // Pending slot: 77 is overwritten by 5 before the first finishes.
    applyStimulus(1'b1, 42);
    idle(3);
    applyStimulus(1'b1, 77);
    idle(2);
    applyStimulus(1'b1, 5);
    idle(50);

    // Boundaries around the largest displayable value and zero.
    applyStimulus(1'b1, 9999);
    idle(40);
    applyStimulus(1'b1, 10000);
    idle(40);
    applyStimulus(1'b1, 0);
    idle(40);
    applyStimulus(1'b1, 7);
    idle(40);

    // Strobe landing in the COMMIT cycle, then one right after commit.
    applyStimulus(1'b1, 300);
    idle(14);
    applyStimulus(1'b1, 888);
    idle(40);
    applyStimulus(1'b1, 301);
    idle(15);
    applyStimulus(1'b1, 6502);
    idle(40);

    // Reset during SHIFT cycle 5 with a load pending.
    applyStimulus(1'b1, 12000);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 77);
    idle(3);
    applyReset();
    idle(40);

    // Randomized strobes and scores, including the overflow range.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 5);
      if (r == 0) begin
        case ($urandom_range(0, 3))
          0:       applyStimulus(1'b1, 9999);
          1:       applyStimulus(1'b1, 10000);
          default: applyStimulus(1'b1, int'($urandom_range(0, (1 << SW) - 1)));
        endcase
      end else begin
        applyStimulus(1'b0, 0);
      end
    end
    idle(50);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
